mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 22 ++
 rtl/mem_map.vh | 16 +
 rtl/uart_tx_core.sv | 87 ++++++++
 rtl/mem_ctrl.sv | 127 ++++++++++++
 tb/tb_mem_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and address helpers for the memory controller.
// Pulls in the MMIO map so modules only need to import this package.
package mem_ctrl_pkg;

`include "mem_map.vh"

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

    // Word-granular address match; byte offset bits are ignored.
    function automatic logic word_hit(
        input logic [31:0] a,
        input logic [31:0] b
    );
        return a[31:2] == b[31:2];
    endfunction

endpackage

// File: rtl/mem_map.vh
// MMIO address map and STATUS register bit positions.
// Included into mem_ctrl_pkg so every file sees one copy of the map.
`ifndef MEM_MAP_VH
`define MEM_MAP_VH

localparam logic [31:0] MMIO_BASE   = 32'hFFFF_F000;
localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_F000;
localparam logic [31:0] ADDR_STATUS = 32'hFFFF_F004;
localparam logic [31:0] ADDR_CYCLES = 32'hFFFF_F008;

localparam int STAT_FULL  = 0;
localparam int STAT_EMPTY = 1;
localparam int STAT_BUSY  = 2;
localparam int STAT_OVF   = 3;

`endif

// File: rtl/uart_tx_core.sv
// 8N1 UART serializer: pulls one byte when idle, shifts it out LSB first.
// pop is asserted in IDLE whenever a byte is offered, consuming it that edge.
module uart_tx_core
    import mem_ctrl_pkg::*;
#(
    parameter int BAUD_DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       pop,
    output logic       busy,
    output logic       tx
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    uart_state_t   state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          baud_end;

    assign baud_end = baud_cnt == CNT_LAST;
    assign pop      = reset && (state == UART_IDLE) && tx_valid;
    assign busy     = state != UART_IDLE;

    // Frame sequencer; each state holds for one baud period.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= UART_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            unique case (state)
                UART_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (tx_valid) begin
                        shift <= tx_byte;
                        tx    <= 1'b0;
                        state <= UART_START;
                    end
                end
                UART_START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        tx       <= shift[0];
                        state    <= UART_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                UART_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            tx      <= 1'b1;
                            state   <= UART_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shift[1];
                            shift   <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                UART_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= UART_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= UART_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// CPU-facing memory controller: word RAM, MMIO decode, cycle counter, TX FIFO.
// Reads are combinational; the UART core drains the FIFO on its own.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_WORDS  = 1024,
    parameter int BAUD_DIV   = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data_out,
    input  logic        data_rw,
    output logic [31:0] data_in,
    output logic        uart_tx
);

    localparam int IDX_W = $clog2(RAM_WORDS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [31:0]      ram [RAM_WORDS];
    logic [7:0]       fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             overflow;
    logic [31:0]      cycles;

    logic [IDX_W-1:0] ram_idx;
    logic             is_mmio;
    logic             sel_tx;
    logic             sel_status;
    logic             sel_cycles;
    logic             we;
    logic             full;
    logic             empty;
    logic             busy;
    logic             pop;
    logic             push;
    logic [3:0]       status;
    logic             addr_unused;

    assign addr_unused = ^address[1:0];
    assign ram_idx     = address[IDX_W+1:2];
    assign is_mmio     = address[31:12] == MMIO_BASE[31:12];
    assign sel_tx      = word_hit(address, ADDR_TXDATA);
    assign sel_status  = word_hit(address, ADDR_STATUS);
    assign sel_cycles  = word_hit(address, ADDR_CYCLES);
    assign we          = data_rw && reset;
    assign full        = count == CNT_FULL;
    assign empty       = count == '0;
    // A full FIFO still accepts a push when the UART pops on the same edge.
    assign push        = we && sel_tx && (!full || pop);

    // Assemble the STATUS word from the FIFO and UART flags.
    always_comb begin
        status             = '0;
        status[STAT_FULL]  = full;
        status[STAT_EMPTY] = empty;
        status[STAT_BUSY]  = busy;
        status[STAT_OVF]   = overflow;
    end

    // Zero-latency read mux driven straight from the address.
    always_comb begin
        data_in = '0;
        unique case (1'b1)
            !is_mmio:   data_in = ram[ram_idx];
            sel_status: data_in = {28'b0, status};
            sel_cycles: data_in = cycles;
            default:    data_in = '0;
        endcase
    end

    // RAM storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (we && !is_mmio)
            ram[ram_idx] <= data_out;
    end

    // FIFO data array; only the pointers need resetting.
    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= data_out[7:0];
    end

    // FIFO pointers, occupancy, sticky overflow and the free-running counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            cycles   <= '0;
        end else begin
            cycles <= cycles + 32'd1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (we && sel_tx && full && !pop)
                overflow <= 1'b1;
            else if (we && sel_status && data_out[STAT_OVF])
                overflow <= 1'b0;
        end
    end

    uart_tx_core #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart (
        .clk     (clk),
        .reset   (reset),
        .tx_byte (fifo[rd_ptr]),
        .tx_valid(!empty),
        .pop     (pop),
        .busy    (busy),
        .tx      (uart_tx)
    );

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: RAM aliasing, MMIO, UART framing, FIFO limits, reset.
// A background receiver decodes uart_tx so transmitted bytes can be compared.
module tb_mem_ctrl;

    localparam int BAUD = 4;
    localparam logic [31:0] A_TX  = 32'hFFFF_F000;
    localparam logic [31:0] A_ST  = 32'hFFFF_F004;
    localparam logic [31:0] A_CY  = 32'hFFFF_F008;
    localparam logic [31:0] A_UNM = 32'hFFFF_F00C;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] data_out = '0;
    logic        data_rw = 1'b0;
    logic [31:0] data_in;
    logic        uart_tx;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_cycles = '0;
    logic [7:0]  rxq[$];
    logic [9:0]  frame;
    logic [7:0]  exp_bytes[$];
    bit          hit;

    mem_ctrl #(
        .RAM_WORDS (1024),
        .BAUD_DIV  (BAUD),
        .FIFO_DEPTH(8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .data_out(data_out),
        .data_rw (data_rw),
        .data_in (data_in),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    // Reference cycle counter.
    always @(posedge clk) exp_cycles <= reset ? exp_cycles + 32'd1 : 32'd0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic rd(input logic [31:0] a);
        address = a;
        data_rw = 1'b0;
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a,
                          input logic [31:0] exp);
        rd(a);
        check(tag, data_in, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        address  = a;
        data_out = d;
        data_rw  = 1'b1;
        cyc();
        data_rw  = 1'b0;
    endtask

    // Serial receiver sampling mid-bit on falling clock edges.
    initial begin : rx_mon
        logic [7:0] b;
        b = '0;
        forever begin
            @(negedge clk);
            if (reset && uart_tx === 1'b0) begin
                repeat (BAUD / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (BAUD) @(negedge clk);
                check("stop_bit", {31'b0, uart_tx}, 32'd1);
                rxq.push_back(b);
            end
        end
    end

    // Hard stop in case something wedges.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        // Reset state
        repeat (3) cyc();
        rd_chk("rst_status", A_ST, 32'h2);
        check("rst_tx", {31'b0, uart_tx}, 32'd1);
        rd_chk("rst_cycles", A_CY, 32'd0);
        reset = 1'b1;
        rd_chk("rel_cycles0", A_CY, 32'd0);
        cyc();
        rd_chk("rel_cycles1", A_CY, 32'd1);

        // RAM write/read and aliasing
        wr(32'h0000_0010, 32'hDEADBEEF);
        rd_chk("ram_rd", 32'h0000_0010, 32'hDEADBEEF);
        rd_chk("ram_alias", 32'h0000_1010, 32'hDEADBEEF);
        wr(32'h0000_0014, 32'h1234_5678);
        wr(32'h0000_0018, 32'hCAFE_F00D);
        rd_chk("ram_b2b_0", 32'h0000_0014, 32'h1234_5678);
        rd_chk("ram_b2b_1", 32'h0000_0018, 32'hCAFE_F00D);
        rd_chk("ram_hi_alias", 32'hFFFF_E014, 32'h1234_5678);

        // Unmapped and read-only MMIO
        rd_chk("unmapped_rd", A_UNM, 32'h0);
        rd_chk("txdata_rd", A_TX, 32'h0);
        wr(A_CY, 32'h0);
        rd_chk("cycles_wr", A_CY, exp_cycles);
        wr(A_UNM, 32'hFFFF_FFFF);
        rd_chk("unm_wr_status", A_ST, 32'h2);

        // Single frame: 0x155 sends 0x55
        wr(A_TX, 32'h155);
        rd_chk("tx_queued", A_ST, 32'h0);
        cyc();
        frame = {1'b1, 8'h55, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < BAUD; k++) begin
                check($sformatf("frame_bit%0d_%0d", b, k),
                      {31'b0, uart_tx}, {31'b0, frame[b]});
                rd_chk($sformatf("frame_busy%0d_%0d", b, k), A_ST, 32'h6);
                cyc();
            end
        end
        rd_chk("tx_done", A_ST, 32'h2);

        // Fill the FIFO, then overflow it
        for (int i = 0; i < 9; i++)
            wr(A_TX, 32'hA0 + i);
        rd_chk("fifo_full", A_ST, 32'h5);
        wr(A_TX, 32'hAA);
        wr(A_TX, 32'hAB);
        rd_chk("ovf_set", A_ST, 32'hD);
        wr(A_ST, 32'h7);
        rd_chk("ovf_hold", A_ST, 32'hD);
        wr(A_ST, 32'h8);
        rd_chk("ovf_clr", A_ST, 32'h5);

        // Push on the IDLE pop edge with the FIFO full
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            rd(A_ST);
            if (data_in[2] == 1'b0)
                hit = 1'b1;
            else
                cyc();
        end
        check("idle_wait", {31'b0, hit}, 32'd1);
        check("idle_full", data_in, 32'h1);
        wr(A_TX, 32'hB0);
        rd_chk("push_pop_full", A_ST, 32'h5);

        // Drain and compare every received byte
        hit = 1'b0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            rd(A_ST);
            if (data_in == 32'h2)
                hit = 1'b1;
            else
                cyc();
        end
        check("drain_wait", {31'b0, hit}, 32'd1);
        repeat (2) cyc();
        exp_bytes = '{8'h55, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4,
                      8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hB0};
        check("rx_count", rxq.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size(); i++) begin
            if (i < rxq.size())
                check($sformatf("rx_byte%0d", i), {24'b0, rxq[i]},
                      {24'b0, exp_bytes[i]});
        end

        // Reset mid-frame, during the DATA state
        wr(A_TX, 32'h3C);
        wr(A_TX, 32'h11);
        repeat (8) cyc();
        check("mid_data_tx", {31'b0, uart_tx}, 32'd0);
        rd_chk("mid_data_status", A_ST, 32'h4);
        reset    = 1'b0;
        address  = 32'h0000_0010;
        data_out = 32'h0;
        data_rw  = 1'b1;
        cyc();
        data_rw = 1'b0;
        check("abort_tx", {31'b0, uart_tx}, 32'd1);
        rd_chk("abort_status", A_ST, 32'h2);
        rd_chk("rst_ram_kept", 32'h0000_0010, 32'hDEADBEEF);
        reset = 1'b1;
        rd_chk("rel2_cycles0", A_CY, 32'd0);
        cyc();
        rd_chk("rel2_cycles1", A_CY, 32'd1);
        repeat (3) cyc();
        check("discard_tx", {31'b0, uart_tx}, 32'd1);
        rd_chk("discard_status", A_ST, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
